// File: rtl/addsub_pkg.sv
// Shared definitions for the serial add/sub datapath: FSM encoding and
// the sizing rule for the chunk counter.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A single-chunk operation still needs a 1-bit counter.
    function automatic int cnt_width(input int nchunk);
        return (nchunk <= 2) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/addsub_serial_chunk.sv
// CHUNK-bit ripple slice; also exposes the carry into its top bit so the
// caller can form signed overflow on the final chunk.
module addsub_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout     = carry[CHUNK];
        c_msb_in = carry[CHUNK-1];
    end

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle two's-complement adder/subtractor: one CHUNK-bit slice is
// reused LSB-first across WIDTH bits, with valid/ready on both sides.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] acc_next;

    // Operands are shifted down each RUN cycle, so the slice always sees bit 0 upward.
    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_q[CHUNK-1:0]),
        .b        (b_q[CHUNK-1:0]),
        .cin      (carry_q),
        .sum      (slice_sum),
        .cout     (slice_cout),
        .c_msb_in (slice_cmsb)
    );

    assign acc_next = (acc_q >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        co_d        = co_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b ^ {WIDTH{sub}};
                    carry_d    = ci ^ sub;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                acc_d   = acc_next;
                carry_d = slice_cout;
                if (cnt_q == LAST) begin
                    result_d = acc_next;
                    co_d     = slice_cout;
                    ovf_d    = slice_cout ^ slice_cmsb;
                    zero_d   = (acc_next == '0);
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // out_valid rises one cycle after entering DONE; the handshake needs it high.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            co_q        <= co_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign co        = co_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench: three 8-bit instances (CHUNK 2, 1, 8) share one stimulus
// stream and must agree with hand-computed results and latencies.
module tb_addsub_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       sub = 1'b0;
    logic       ci = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;

    logic       ir0, ir1, ir2;
    logic       ov0, ov1, ov2;
    logic [7:0] r0, r1, r2;
    logic       co0, co1, co2;
    logic       ovf0, ovf1, ovf2;
    logic       z0, z1, z2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(8), .CHUNK(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .a(a), .b(b), .sub(sub), .ci(ci), .out_valid(ov0), .out_ready(out_ready),
        .result(r0), .co(co0), .ovf(ovf0), .zero(z0)
    );

    addsub_serial #(.WIDTH(8), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .a(a), .b(b), .sub(sub), .ci(ci), .out_valid(ov1), .out_ready(out_ready),
        .result(r1), .co(co1), .ovf(ovf1), .zero(z1)
    );

    addsub_serial #(.WIDTH(8), .CHUNK(8)) dut_c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
        .a(a), .b(b), .sub(sub), .ci(ci), .out_valid(ov2), .out_ready(out_ready),
        .result(r2), .co(co2), .ovf(ovf2), .zero(z2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] ta, input logic [7:0] tbv, input logic ts, input logic tc);
        @(negedge clk);
        check_val("in_ready_before_issue", {31'd0, ir0}, 32'd1);
        a        = ta;
        b        = tbv;
        sub      = ts;
        ci       = tc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge right after the accept edge.
    task automatic collect(input string tag, input logic [7:0] er, input logic eco,
                           input logic eovf, input logic ez, input bit hs);
        int n;
        int l0, l1, l2;
        n = 0; l0 = 0; l1 = 0; l2 = 0;
        while ((l0 == 0 || l1 == 0 || l2 == 0) && n < 40) begin
            @(negedge clk);
            n++;
            if (ov0 && l0 == 0) l0 = n;
            if (ov1 && l1 == 0) l1 = n;
            if (ov2 && l2 == 0) l2 = n;
        end
        check_val({tag, "_lat_c2"}, l0, 32'd5);
        check_val({tag, "_lat_c1"}, l1, 32'd9);
        check_val({tag, "_lat_c8"}, l2, 32'd2);
        check_val({tag, "_res_c2"}, {24'd0, r0}, {24'd0, er});
        check_val({tag, "_res_c1"}, {24'd0, r1}, {24'd0, er});
        check_val({tag, "_res_c8"}, {24'd0, r2}, {24'd0, er});
        check_val({tag, "_flags_c2"}, {29'd0, co0, ovf0, z0}, {29'd0, eco, eovf, ez});
        check_val({tag, "_flags_c1"}, {29'd0, co1, ovf1, z1}, {29'd0, eco, eovf, ez});
        check_val({tag, "_flags_c8"}, {29'd0, co2, ovf2, z2}, {29'd0, eco, eovf, ez});
        if (hs) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_val({tag, "_ov_after_hs"}, {31'd0, ov0}, 32'd0);
            check_val({tag, "_ir_after_hs"}, {31'd0, ir0}, 32'd1);
            check_val({tag, "_hold_in_idle"}, {24'd0, r0}, {24'd0, er});
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", {31'd0, ir0}, 32'd1);
        check_val("rst_out_valid", {31'd0, ov0}, 32'd0);
        check_val("rst_result", {24'd0, r0}, 32'd0);
        check_val("rst_flags", {29'd0, co0, ovf0, z0}, 32'd0);
        rst_n = 1'b1;

        issue(8'h3C, 8'h05, 1'b0, 1'b0); collect("add",     8'h41, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(8'h7F, 8'h7F, 1'b1, 1'b0); collect("sub0",    8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        issue(8'h7F, 8'h01, 1'b0, 1'b0); collect("ovf_add", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(8'h80, 8'h01, 1'b1, 1'b0); collect("ovf_sub", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(8'h00, 8'h00, 1'b1, 1'b1); collect("borrow",  8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(8'hFF, 8'h01, 1'b0, 1'b0); collect("wrap",    8'h00, 1'b1, 1'b0, 1'b1, 1'b1);

        // Backpressure: hold the result while a new operand waits.
        issue(8'h3C, 8'h05, 1'b0, 1'b0); collect("bp", 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
        a = 8'h11; b = 8'h22; sub = 1'b0; ci = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("bp_out_valid", {31'd0, ov0}, 32'd1);
            check_val("bp_result", {24'd0, r0}, 32'h41);
            check_val("bp_in_ready", {31'd0, ir0}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("bp_release_ov", {31'd0, ov0}, 32'd0);
        check_val("bp_release_ir", {31'd0, ir0}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        collect("queued", 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset two RUN cycles into an operation.
        issue(8'h3C, 8'h05, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", {31'd0, ov0}, 32'd0);
        check_val("midrst_result", {24'd0, r0}, 32'd0);
        check_val("midrst_in_ready", {31'd0, ir0}, 32'd1);
        check_val("midrst_flags", {29'd0, co0, ovf0, z0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h3C, 8'h05, 1'b0, 1'b0); collect("post_rst", 8'h41, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
